// File: rtl/user_obi_arb.sv
// Two-manager OBI arbiter in front of a single user-design subordinate window.
// Out-of-window requests are answered locally with an error response.
module user_obi_arb #(
  parameter int                   AddrWidth     = 32,
  parameter int                   DataWidth     = 32,
  parameter logic [AddrWidth-1:0] WinBase       = 32'h2000_0000,
  parameter logic [AddrWidth-1:0] WinSize       = 32'h0000_1000,
  parameter int                   TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                m_req_i,
  output logic [1:0]                m_gnt_o,
  input  logic [1:0][AddrWidth-1:0] m_addr_i,
  input  logic [1:0]                m_we_i,
  input  logic [1:0][3:0]           m_be_i,
  input  logic [1:0][DataWidth-1:0] m_wdata_i,
  output logic [1:0]                m_rvalid_o,
  output logic [1:0][DataWidth-1:0] m_rdata_o,
  output logic [1:0]                m_err_o,
  output logic                      s_req_o,
  input  logic                      s_gnt_i,
  output logic [AddrWidth-1:0]      s_addr_o,
  output logic                      s_we_o,
  output logic [3:0]                s_be_o,
  output logic [DataWidth-1:0]      s_wdata_o,
  input  logic                      s_rvalid_i,
  input  logic [DataWidth-1:0]      s_rdata_i,
  input  logic                      s_err_i,
  output logic                      timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  // One extra bit so the window end never wraps.
  localparam logic [AddrWidth:0] WinEnd = {1'b0, WinBase} + {1'b0, WinSize};
  localparam logic [15:0]        TmoLim = 16'(TimeoutCycles);

  state_t      r_state;
  logic        r_rr;
  logic        r_owner;
  logic [15:0] r_timer;

  logic                 w_sel, w_any, w_in_win;
  logic                 w_idle, w_wait, w_err, w_fwd, w_oow, w_tmo;
  logic [AddrWidth:0]   w_addr_x;
  logic                 w_rsp_vld, w_rsp_err;
  logic [DataWidth-1:0] w_rsp_data;

  assign w_any    = |m_req_i;
  assign w_sel    = (m_req_i == 2'b11) ? r_rr : m_req_i[1];
  assign w_addr_x = {1'b0, m_addr_i[w_sel]};
  assign w_in_win = (w_addr_x >= {1'b0, WinBase}) && (w_addr_x < WinEnd);

  // Outputs are forced low while reset is held, independent of state.
  assign w_idle = !rst_i && (r_state == IDLE);
  assign w_wait = !rst_i && (r_state == WAIT);
  assign w_err  = !rst_i && (r_state == ERR);
  assign w_fwd  = w_idle && w_any && w_in_win;
  assign w_oow  = w_idle && w_any && !w_in_win;
  // A response arriving in the limit cycle wins over the timeout.
  assign w_tmo  = w_wait && !s_rvalid_i && (r_timer == TmoLim);
  assign timeout_o = w_tmo;

  always_comb begin
    s_req_o   = w_fwd;
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (w_fwd) begin
      s_addr_o  = m_addr_i[w_sel];
      s_we_o    = m_we_i[w_sel];
      s_be_o    = m_be_i[w_sel];
      s_wdata_o = m_wdata_i[w_sel];
    end
    m_gnt_o = '0;
    if ((w_fwd && s_gnt_i) || w_oow) m_gnt_o[w_sel] = 1'b1;

    w_rsp_vld  = 1'b0;
    w_rsp_err  = 1'b0;
    w_rsp_data = '0;
    if (w_wait) begin
      w_rsp_vld  = s_rvalid_i || w_tmo;
      w_rsp_err  = w_tmo || s_err_i;
      w_rsp_data = w_tmo ? '0 : s_rdata_i;
    end else if (w_err) begin
      w_rsp_vld = 1'b1;
      w_rsp_err = 1'b1;
    end
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    m_rvalid_o[r_owner] = w_rsp_vld;
    m_err_o[r_owner]    = w_rsp_err;
    m_rdata_o[r_owner]  = w_rsp_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fwd && s_gnt_i) begin
            r_owner <= w_sel;
            r_rr    <= ~w_sel;
            r_timer <= '0;
            r_state <= WAIT;
          end else if (w_oow) begin
            r_owner <= w_sel;
            r_rr    <= ~w_sel;
            r_state <= ERR;
          end
        end
        WAIT: begin
          if (s_rvalid_i || w_tmo) r_state <= IDLE;
          else                     r_timer <= r_timer + 16'd1;
        end
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
